// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the CPU/loader memory arbiter.
package mem_arb_pkg;

    // Widest byte address the range helper accepts; callers zero-extend into it.
    localparam int ADDR_MAX = 64;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_LDR  = 2'd2
    } grant_e;

    // True when a word index falls past the end of the memory array.
    function automatic logic word_oob(input logic [ADDR_MAX-1:0] widx,
                                      input int unsigned         words);
        return widx >= ADDR_MAX'(words);
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way requester picker: single requester wins outright, ties go by
// fixed CPU priority or alternate away from the last granted port.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] eligible,   // {cpu, ldr}
    input  grant_e     last,
    input  logic       fixed_prio,
    output grant_e     grant
);

    // Resolve the grant for this IDLE cycle.
    always_comb begin
        grant = GNT_NONE;
        case (eligible)
            2'b10:   grant = GNT_CPU;
            2'b01:   grant = GNT_LDR;
            2'b11:   grant = (fixed_prio || last != GNT_CPU) ? GNT_CPU : GNT_LDR;
            default: grant = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified memory port between the CPU and the program loader.
// Each access is IDLE (arbitrate) followed by a single ACCESS cycle in
// which the granted port drives memory and receives its ack.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e state_q;
    grant_e grant_q, last_q, pick;

    logic [1:0]        eligible;
    logic              in_acc;
    logic              sel_ldr;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              acc_err;

    // Lock hides the CPU from arbitration; it only matters while in IDLE.
    assign eligible = {cpu_req & ~ldr_lock, ldr_req};

    mem_arb_rr u_rr (
        .eligible   (eligible),
        .last       (last_q),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (pick)
    );

    // Reset in the ACCESS cycle suppresses the write and the ack.
    assign in_acc  = (state_q == ST_ACCESS) && !reset;
    assign sel_ldr = (grant_q == GNT_LDR);
    assign g_we    = sel_ldr ? ldr_we    : cpu_we;
    assign g_addr  = sel_ldr ? ldr_addr  : cpu_addr;
    assign g_wdata = sel_ldr ? ldr_wdata : cpu_wdata;
    assign acc_err = (g_addr[1:0] != 2'b00) ||
                     word_oob(ADDR_MAX'(g_addr[ADDR_W-1:2]), MEM_WORDS);

    // Drive memory and the granted port's completion during ACCESS only.
    always_comb begin
        mem_we    = in_acc & g_we & ~acc_err;
        mem_addr  = in_acc ? g_addr  : '0;
        mem_wdata = in_acc ? g_wdata : '0;
        cpu_ack   = in_acc & (grant_q == GNT_CPU);
        ldr_ack   = in_acc & sel_ldr;
        cpu_err   = cpu_ack & acc_err;
        ldr_err   = ldr_ack & acc_err;
        cpu_rdata = (cpu_ack && !acc_err) ? mem_rdata : '0;
        ldr_rdata = (ldr_ack && !acc_err) ? mem_rdata : '0;
        busy      = in_acc;
    end

    // Arbitrate in IDLE, spend exactly one cycle in ACCESS, remember the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= GNT_NONE;
            last_q  <= GNT_LDR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        grant_q <= pick;
                        state_q <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    last_q  <= grant_q;
                    grant_q <= GNT_NONE;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: round-robin and fixed-priority
// instances, a small memory model, and a negedge monitor popping expectations.
module tb_mem_arbiter;

    typedef struct {
        logic        ldr;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    // round-robin instance
    logic        cpu_req = 0, cpu_we = 0, cpu_ack, cpu_err;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
    logic        ldr_req = 0, ldr_we = 0, ldr_lock = 0, ldr_ack, ldr_err;
    logic [31:0] ldr_addr = 0, ldr_wdata = 0, ldr_rdata;
    logic        mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    // fixed-priority instance
    logic        f_cpu_req = 0, f_cpu_ack, f_cpu_err;
    logic [31:0] f_cpu_addr = 0, f_cpu_rdata;
    logic        f_ldr_req = 0, f_ldr_ack, f_ldr_err;
    logic [31:0] f_ldr_addr = 0, f_ldr_rdata;
    logic        f_mem_we, f_busy;
    logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;

    logic [31:0] mem [0:63];
    int          total = 0, bad = 0, we_cnt = 0;
    exp_t        exp_q[$], fexp_q[$];
    exp_t        m_e, f_e;
    int          lat;
    logic        ack_we;
    logic [31:0] ack_addr;
    logic [7:0]  cs, ls;
    int          we_snap;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(64), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata), .ldr_err(ldr_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(64), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .cpu_req(f_cpu_req), .cpu_we(1'b0), .cpu_addr(f_cpu_addr), .cpu_wdata(32'h0),
        .cpu_ack(f_cpu_ack), .cpu_rdata(f_cpu_rdata), .cpu_err(f_cpu_err),
        .ldr_req(f_ldr_req), .ldr_we(1'b0), .ldr_addr(f_ldr_addr), .ldr_wdata(32'h0),
        .ldr_lock(1'b0), .ldr_ack(f_ldr_ack), .ldr_rdata(f_ldr_rdata), .ldr_err(f_ldr_err),
        .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata), .busy(f_busy)
    );

    // Memory model: combinational read, write committed at the closing edge.
    assign mem_rdata   = mem[mem_addr[7:2]];
    assign f_mem_rdata = f_mem_addr ^ 32'h5A5A_0000;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for the round-robin instance.
    always @(negedge clk) begin
        if (cpu_ack || ldr_ack) begin
            if (cpu_ack && ldr_ack) begin
                total++; bad++;
                $display("FAIL both_ack: got cpu=1 ldr=1 want one at %0t", $time);
            end else if ((cpu_ack && !cpu_req) || (ldr_ack && !ldr_req)) begin
                total++; bad++;
                $display("FAIL req_dropped: ack without held req at %0t", $time);
            end else if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL sb_empty: got unexpected ack (ldr=%0b) at %0t", ldr_ack, $time);
            end else begin
                m_e = exp_q.pop_front();
                chk("sb_port",  32'(ldr_ack), 32'(m_e.ldr));
                chk("sb_rdata", ldr_ack ? ldr_rdata : cpu_rdata, m_e.rdata);
                chk("sb_err",   32'(ldr_ack ? ldr_err : cpu_err), 32'(m_e.err));
            end
        end
    end

    // Scoreboard monitor for the fixed-priority instance.
    always @(negedge clk) begin
        if (f_cpu_ack || f_ldr_ack) begin
            if (f_cpu_ack && f_ldr_ack) begin
                total++; bad++;
                $display("FAIL fp_both_ack: got cpu=1 ldr=1 want one at %0t", $time);
            end else if (fexp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL fp_sb_empty: got unexpected ack (ldr=%0b) at %0t", f_ldr_ack, $time);
            end else begin
                f_e = fexp_q.pop_front();
                chk("fp_sb_port",  32'(f_ldr_ack), 32'(f_e.ldr));
                chk("fp_sb_rdata", f_ldr_ack ? f_ldr_rdata : f_cpu_rdata, f_e.rdata);
                chk("fp_sb_err",   32'(f_ldr_ack ? f_ldr_err : f_cpu_err), 32'(f_e.err));
            end
        end
    end

    // One access on the round-robin instance; lat counts cycles until ack.
    task automatic acc(input logic is_ldr, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        if (is_ldr) begin
            ldr_req = 1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_ldr ? ldr_ack : cpu_ack) begin
                got = 1'b1;
                ack_we = mem_we;
                ack_addr = mem_addr;
                break;
            end
            lat++;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: got no ack want ack within 20 cycles");
        end
        @(posedge clk); #1;
        cpu_req = 0; ldr_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish want finish by 100us");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_cpu_ack", 32'(cpu_ack), 0);
        chk("rst_ldr_ack", 32'(ldr_ack), 0);
        chk("rst_mem_we",  32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_fp_busy", 32'(f_busy), 0);
        @(posedge clk); #1;
        reset = 0;

        // loader write then read-back
        exp_q.push_back('{1'b1, 32'hA000_0008, 1'b0});
        acc(1, 1, 32'h20, 32'h0062_A023);
        chk("ldw_latency", 32'(lat), 1);
        chk("ldw_mem_we", 32'(ack_we), 1);
        chk("ldw_mem_addr", ack_addr, 32'h20);
        chk("ldw_we_count", 32'(we_cnt), 1);
        exp_q.push_back('{1'b1, 32'h0062_A023, 1'b0});
        acc(1, 0, 32'h20, 32'h0);
        chk("ldr_latency", 32'(lat), 1);

        // round robin with both held: CPU first (last was LDR), then alternate
        exp_q.push_back('{1'b0, 32'h0062_A023, 1'b0});
        exp_q.push_back('{1'b1, 32'hA000_0009, 1'b0});
        exp_q.push_back('{1'b0, 32'h0062_A023, 1'b0});
        exp_q.push_back('{1'b1, 32'hA000_0009, 1'b0});
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h24;
        cs = 0; ls = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs[i] = cpu_ack; ls[i] = ldr_ack;
        end
        @(posedge clk); #1;
        cpu_req = 0; ldr_req = 0;
        chk("rr_cpu_slots", 32'(cs), 32'h22);
        chk("rr_ldr_slots", 32'(ls), 32'h88);

        // fixed priority: CPU every other cycle, loader only after CPU drops
        fexp_q.push_back('{1'b0, 32'h5A5A_0010, 1'b0});
        fexp_q.push_back('{1'b0, 32'h5A5A_0010, 1'b0});
        fexp_q.push_back('{1'b0, 32'h5A5A_0010, 1'b0});
        fexp_q.push_back('{1'b1, 32'h5A5A_0014, 1'b0});
        @(posedge clk); #1;
        f_cpu_req = 1; f_cpu_addr = 32'h10;
        f_ldr_req = 1; f_ldr_addr = 32'h14;
        cs = 0; ls = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs[i] = f_cpu_ack; ls[i] = f_ldr_ack;
            if (i == 5) begin
                @(posedge clk); #1;
                f_cpu_req = 0;
            end
        end
        @(posedge clk); #1;
        f_ldr_req = 0;
        chk("fp_cpu_slots", 32'(cs), 32'h2A);
        chk("fp_ldr_slots", 32'(ls), 32'h80);

        // loader lock starves the CPU; release lets it in next arbitration
        exp_q.push_back('{1'b1, 32'hA000_000A, 1'b0});
        exp_q.push_back('{1'b1, 32'hA000_000A, 1'b0});
        exp_q.push_back('{1'b1, 32'hA000_000A, 1'b0});
        exp_q.push_back('{1'b0, 32'h0062_A023, 1'b0});
        @(posedge clk); #1;
        ldr_lock = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
        ldr_req = 1; ldr_we = 0; ldr_addr = 32'h28;
        cs = 0; ls = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cs[i] = cpu_ack; ls[i] = ldr_ack;
            if (i == 5) begin
                @(posedge clk); #1;
                ldr_req = 0; ldr_lock = 0;
            end
        end
        @(posedge clk); #1;
        cpu_req = 0;
        chk("lock_cpu_slots", 32'(cs), 32'h80);
        chk("lock_ldr_slots", 32'(ls), 32'h2A);

        // error accesses: misaligned, then one word past the end
        we_snap = we_cnt;
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        acc(0, 1, 32'h102, 32'h1234_5678);
        chk("mis_mem_we", 32'(ack_we), 0);
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        acc(0, 1, 32'h100, 32'h1234_5678);
        chk("oob_mem_we", 32'(ack_we), 0);
        chk("err_we_count", 32'(we_cnt), 32'(we_snap));

        // last valid word
        exp_q.push_back('{1'b0, 32'hA000_003F, 1'b0});
        acc(0, 1, 32'hFC, 32'h1111_2222);
        chk("top_mem_we", 32'(ack_we), 1);
        chk("top_mem_addr", ack_addr, 32'hFC);
        exp_q.push_back('{1'b0, 32'h1111_2222, 1'b0});
        acc(0, 0, 32'hFC, 32'h0);

        // reset in the ACCESS cycle of a CPU write
        we_snap = we_cnt;
        @(posedge clk); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("rsta_mem_we",  32'(mem_we), 0);
        chk("rsta_cpu_ack", 32'(cpu_ack), 0);
        chk("rsta_cpu_err", 32'(cpu_err), 0);
        @(posedge clk); #1;
        reset = 0; cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        chk("rsta_busy_after", 32'(busy), 0);
        chk("rsta_ack_after", 32'(cpu_ack), 0);
        chk("rsta_mem_word", mem[12], 32'hA000_000C);
        chk("rsta_we_count", 32'(we_cnt), 32'(we_snap));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", 32'(exp_q.size()), 0);
        chk("fp_sb_drain", 32'(fexp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the unified instruction/data memory of the multicycle RISC-V core.
- Shares the single memory port between the CPU and a program loader/debug port, which preloads programs and reads back results.
- Sequences each access as a two-state handshake: arbitrate, then access.
- Checks alignment and range before any write reaches memory.

Parameters:
DATA_W, 32, data width of all data buses
ADDR_W, 32, byte-address width
MEM_WORDS, 64, words in memory; word index = addr[ADDR_W-1:2]
FIXED_PRIO, 0, 0 = round-robin; 1 = CPU always wins ties

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request; held stable until cpu_ack
cpu_we  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1
cpu_err  out  1  pulses with cpu_ack on misaligned/out-of-range access
ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as CPU
ldr_lock  in  1  when high, only the loader is eligible for grant
ldr_ack, ldr_rdata, ldr_err  out  1/DATA_W/1  loader completion, same rules as CPU
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  combinational read data from memory
busy  out  1  high in ACCESS state

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset: state=IDLE, grant_q=NONE, last_q=LDR (CPU wins first tie). All acks, errs, mem_we and busy are 0. mem_addr, mem_wdata, rdata outputs are 0.
- IDLE:
  - eligible = {cpu_req & ~ldr_lock, ldr_req}.
  - If none eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible: with FIXED_PRIO=1, grant CPU; otherwise grant the requester that is not last_q.
  - Register grant_q, go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr/mem_wdata are muxed combinationally from the granted port.
  - err = addr[1:0]!=0 OR addr[ADDR_W-1:2] >= MEM_WORDS.
  - mem_we = granted we & ~err & ~reset. The write commits at the closing edge.
  - Granted port's ack=1. rdata = mem_rdata, or 0 if err. err output as computed.
  - last_q <= grant_q; grant_q <= NONE; go to IDLE.
  - The non-granted port's outputs stay 0.
- Throughput and latency: request seen in IDLE at cycle t gives ack at t+1. A master that re-asserts or keeps req high is re-arbitrated at t+2. Max rate is 1 access per 2 cycles per arbiter.
- Round-robin guarantee: with both requesting continuously and lock low, grants strictly alternate. Worst-case wait is 3 cycles.
- ldr_lock:
  - Sampled only in IDLE.
  - Asserting it while the CPU is in ACCESS does not abort that access.
  - While lock is high, cpu_req waits indefinitely with cpu_ack=0.
- Req dropped before ack: a protocol violation. The arbiter still completes the granted access using the current inputs. The bench must not do this; an assertion flags it.
- Reset during ACCESS: no write occurs, no ack or err is produced, next state is IDLE.
- Error accesses: consume the cycle and produce ack+err. No write, rdata=0.

Decomposition:
- Package mem_arb_pkg:
  - state encoding IDLE/ACCESS
  - grant encoding NONE/CPU/LDR (2 bits)
  - helper function for the word-index range check
- Sub-module mem_arb_rr:
  - 2-way round-robin picker with inputs eligible[1:0], last, fixed_prio and output grant.
  - Purely combinational. The FSM and datapath muxes stay in mem_arbiter.

Test Plan:
- Reset then ldr write addr=0x20, data=0x0062A023 → ldr_ack at cycle+1, mem_we=1 once, mem_addr=0x20; ldr read of 0x20 returns 0x0062A023 with ldr_ack.
- cpu_req and ldr_req rise together, FIXED_PRIO=0, both held for 4 accesses → grant order CPU, LDR, CPU, LDR; acks at cycles 1, 3, 5, 7.
- Same stimulus with FIXED_PRIO=1 → CPU acked every 2 cycles; ldr_ack only after cpu_req drops.
- ldr_lock=1, both requesting for 6 cycles → only ldr_ack pulses and cpu_ack=0; lock drops → cpu_ack within 3 cycles.
- CPU write addr=0x102 (misaligned), then addr=0x100 (index 64 ≥ MEM_WORDS) → cpu_ack=1 with cpu_err=1 each time, mem_we never asserted, cpu_rdata=0.
- Assert reset in the ACCESS cycle of a CPU write → mem_we=0, cpu_ack=0, memory unchanged; next cycle state=IDLE and busy=0.
